// File: rtl/ks_chunk_sequencer.sv
// Multi-cycle wide adder: slices W-bit operands into 4-bit chunks and runs
// them LSB first through a single 4-bit Kogge-Stone core, chaining the
// carry between chunks through a register.

// 4-bit Kogge-Stone adder core: {cout, sum[3:0]} = a + b + cin.
// The carry-in is treated as an extra generate bit below bit 0, so the
// prefix tree spans five positions and needs three levels.
module ks_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [4:0] sum
);
    logic [4:0] g0, p0, g1, p1, g2, g3;
    logic       p2_top;

    assign g0 = {a & b, cin};
    assign p0 = {a ^ b, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_tree
            // Distance-1 combine
            if (gi >= 1) begin : g_l1
                assign g1[gi] = g0[gi] | (p0[gi] & g0[gi-1]);
                assign p1[gi] = p0[gi] & p0[gi-1];
            end else begin : g_l1_pass
                assign g1[gi] = g0[gi];
                assign p1[gi] = p0[gi];
            end
            // Distance-2 combine
            if (gi >= 2) begin : g_l2
                assign g2[gi] = g1[gi] | (p1[gi] & g1[gi-2]);
            end else begin : g_l2_pass
                assign g2[gi] = g1[gi];
            end
        end
    endgenerate

    // Only the top position still needs a distance-4 combine.
    assign p2_top = p1[4] & p1[2];
    assign g3     = {g2[4] | (p2_top & g2[0]), g2[3:0]};

    // g3[i] is the carry into operand bit i; g3[4] is the carry-out.
    assign sum = {g3[4], (a ^ b) ^ g3[3:0]};
endmodule

module ks_chunk_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   sum,
    output logic         busy
);
    localparam int CHUNKS = W / 4;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  a_sh_reg, b_sh_reg, partial_reg;
    logic          carry_reg;
    logic [CW-1:0] cnt_reg;
    logic [W:0]    sum_reg;

    logic          accept, last_chunk;
    logic [4:0]    core_sum;
    logic [W-1:0]  partial_next;

    ks_add4 u_core (
        .a   (a_sh_reg[3:0]),
        .b   (b_sh_reg[3:0]),
        .cin (carry_reg),
        .sum (core_sum)
    );

    // The newest chunk sum enters from the top; for a single chunk it is the whole result.
    generate
        if (W == 4) begin : g_single
            assign partial_next = core_sum[3:0];
        end else begin : g_multi
            assign partial_next = {core_sum[3:0], partial_reg[W-1:4]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_chunk = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == CW'(CHUNKS - 1)) begin
                    last_chunk = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand shifting, carry chaining and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            partial_reg <= '0;
            carry_reg   <= 1'b0;
            cnt_reg     <= '0;
            sum_reg     <= '0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg    <= a_sh_reg >> 4;
            b_sh_reg    <= b_sh_reg >> 4;
            carry_reg   <= core_sum[4];
            partial_reg <= partial_next;
            cnt_reg     <= cnt_reg + CW'(1);
            if (last_chunk) sum_reg <= {core_sum[4], partial_next};
        end
    end

    assign sum = sum_reg;
endmodule
